mult_input_sequencer: RTL and testbench

//  Top-level controller for the approximate-multiplier test datapath. On each start it walks
//  the 16-entry input memory in pairs: (word 2i, word 2i+1) -> operands A,B -> multiplier.
//  It waits for the multiplier handshake and writes each product to result memory at address i.
//  It is the only master of the input-memory address bus and the multiplier start/done pair.

---
 rtl/mult_pkg.sv | 30 +++
 rtl/mult_pair_counter.sv | 26 ++
 rtl/mult_input_sequencer.sv | 136 +++++++++++++
 tb/tb_mult_input_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants and types for the approximate-multiplier test datapath
// (controller, multiplier and memory blocks).
package mult_pkg;

    localparam int unsigned NUM_WORDS = 16;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned PROD_W    = 32;
    localparam int unsigned NUM_PAIRS = NUM_WORDS / 2;
    localparam int unsigned PAIR_W    = ADDR_W - 1;
    localparam int unsigned TIMEOUT   = 255;
    localparam int unsigned WDOG_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        START_MUL,
        WAIT_MUL,
        WRITE,
        DONE
    } state_t;

    // Input-memory address of one operand of a pair: even word is A, odd word is B.
    function automatic logic [ADDR_W-1:0] pair_addr(input logic [PAIR_W-1:0] idx,
                                                    input logic odd);
        return {idx, odd};
    endfunction

endpackage

// File: rtl/mult_pair_counter.sv
// Pair index for the input sequencer: cleared on run start, advanced after each write,
// with a flag marking the last pair of the memory.
module mult_pair_counter
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [PAIR_W-1:0] count,
    output logic              last_c
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= PAIR_W'(count + 1'b1);
        end
    end

    assign last_c = (count == PAIR_W'(NUM_PAIRS - 1));

endmodule

// File: rtl/mult_input_sequencer.sv
// Walks the input memory in (A,B) pairs, drives the multiplier handshake and writes each
// product to result memory; a watchdog aborts the run if the multiplier never answers.
module mult_input_sequencer
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_word,
    output logic [WORD_W-1:0] op_a,
    output logic [WORD_W-1:0] op_b,
    output logic              mul_start,
    input  logic              mul_done,
    input  logic [PROD_W-1:0] mul_result,
    output logic              wr_en,
    output logic [PAIR_W-1:0] wr_addr,
    output logic [PROD_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t             state;
    logic [WDOG_W-1:0]  wdog;
    logic [PAIR_W-1:0]  pair_idx;
    logic               pair_last;
    logic               pair_clear;
    logic               pair_inc;

    // The index only moves on an accepted start or between pairs; it never wraps mid-run.
    assign pair_clear = (state == IDLE) && start;
    assign pair_inc   = (state == WRITE) && !pair_last;

    mult_pair_counter u_pair_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (pair_clear),
        .inc    (pair_inc),
        .count  (pair_idx),
        .last_c (pair_last)
    );

    // Outputs are registered together with the state so each one is valid for the whole
    // cycle of the state it belongs to (mem_addr in particular, since memory reads combinationally).
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wdog      <= '0;
            mem_addr  <= '0;
            op_a      <= '0;
            op_b      <= '0;
            mul_start <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            wr_en     <= 1'b0;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    mem_addr <= '0;
                    if (start) begin
                        state    <= FETCH_A;
                        mem_addr <= pair_addr('0, 1'b0);
                        error    <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                FETCH_A: begin
                    op_a     <= mem_word;
                    mem_addr <= pair_addr(pair_idx, 1'b1);
                    state    <= FETCH_B;
                end

                FETCH_B: begin
                    op_b      <= mem_word;
                    mul_start <= 1'b1;
                    state     <= START_MUL;
                end

                START_MUL: begin
                    wdog  <= '0;
                    state <= WAIT_MUL;
                end

                // A mul_done already high on the first WAIT cycle is taken immediately.
                WAIT_MUL: begin
                    if (mul_done) begin
                        wr_data <= mul_result;
                        wr_addr <= pair_idx;
                        wr_en   <= 1'b1;
                        state   <= WRITE;
                    end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
                        error    <= 1'b1;
                        done     <= 1'b1;
                        mem_addr <= '0;
                        state    <= DONE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end

                WRITE: begin
                    if (pair_last) begin
                        done     <= 1'b1;
                        mem_addr <= '0;
                        state    <= DONE;
                    end else begin
                        mem_addr <= pair_addr(PAIR_W'(pair_idx + 1'b1), 1'b0);
                        state    <= FETCH_A;
                    end
                end

                DONE: begin
                    busy     <= 1'b0;
                    mem_addr <= '0;
                    state    <= IDLE;
                end

                default: begin
                    busy     <= 1'b0;
                    mem_addr <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_input_sequencer.sv
// Randomized self-checking bench for mult_input_sequencer: behavioural input memory and
// multiplier with variable latency, expected products computed directly from memory contents.
module tb_mult_input_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  mem_addr;
    logic [15:0] mem_word;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        mul_start;
    logic        mul_done;
    logic [31:0] mul_result;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [16];
    int          mode = 0;          // 0: answer next cycle, 1: random 0..10 extra, 2: never
    logic        model_done = 1'b0;
    logic [31:0] model_result = '0;
    logic [31:0] pend_prod = '0;
    int          pend_cnt = 0;
    int          d;
    logic        spur_done = 1'b0;
    int          delays[$];

    logic [2:0]  wq_addr[$];
    logic [31:0] wq_data[$];
    int          n_start = 0;
    int          stab_viol = 0;
    bit          in_flight = 1'b0;
    logic [15:0] lat_a, lat_b;

    logic        first_err;
    logic [3:0]  first_addr;

    always #5 clk = ~clk;

    assign mem_word   = mem[mem_addr];
    assign mul_done   = model_done | spur_done;
    assign mul_result = model_done ? model_result : 32'hDEAD_BEEF;

    mult_input_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_addr   (mem_addr),
        .mem_word   (mem_word),
        .op_a       (op_a),
        .op_b       (op_b),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Multiplier model: product of the operands presented with mul_start, after a delay.
    always @(posedge clk) begin
        model_done <= 1'b0;
        if (mul_start === 1'b1 && mode != 2) begin
            d = (mode == 1) ? int'($urandom_range(0, 10)) : 0;
            delays.push_back(d);
            if (d == 0) begin
                model_done   <= 1'b1;
                model_result <= 32'(op_a) * 32'(op_b);
            end else begin
                pend_cnt  <= d;
                pend_prod <= 32'(op_a) * 32'(op_b);
            end
        end else if (pend_cnt != 0) begin
            if (pend_cnt == 1) begin
                model_done   <= 1'b1;
                model_result <= pend_prod;
            end
            pend_cnt <= pend_cnt - 1;
        end
    end

    // Records result-memory writes, mul_start pulses and operand stability while a multiply is open.
    always @(posedge clk) begin
        if (in_flight && (op_a !== lat_a || op_b !== lat_b)) stab_viol = stab_viol + 1;
        if (wr_en === 1'b1) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
            in_flight = 1'b0;
        end
        if (mul_start === 1'b1) begin
            n_start   = n_start + 1;
            lat_a     = op_a;
            lat_b     = op_b;
            in_flight = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] exp_prod(input int i);
        return 32'(mem[2*i]) * 32'(mem[2*i+1]);
    endfunction

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        delays.delete();
        n_start   = 0;
        stab_viol = 0;
        in_flight = 1'b0;
    endtask

    // Pulses start and returns the cycle (1 = first cycle after acceptance) where done is seen.
    task automatic run_once(input int budget, input bit spur, output int cyc);
        int ph;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        cyc        = 1;
        first_err  = error;
        first_addr = mem_addr;
        while (done !== 1'b1 && cyc < budget) begin
            if (spur && cyc <= 39) begin
                ph        = (cyc - 1) % 5;
                start     = (cyc >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                spur_done = (ph < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
            cyc       = cyc + 1;
            start     = 1'b0;
            spur_done = 1'b0;
        end
        if (done !== 1'b1) cyc = -1;
    endtask

    task automatic check_products(input string tag);
        checks++;
        if (wq_addr.size() !== 8) begin
            errors++;
            $display("FAIL %s write_count: got %0d expected 8", tag, wq_addr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wq_addr[i] !== 3'(i) || wq_data[i] !== exp_prod(i)) begin
                    errors++;
                    $display("FAIL %s write[%0d]: got addr %0d data %0d expected addr %0d data %0d",
                             tag, i, wq_addr[i], wq_data[i], i, exp_prod(i));
                end
            end
        end
        checks++;
        if (n_start !== 8) begin
            errors++;
            $display("FAIL %s mul_start_count: got %0d expected 8", tag, n_start);
        end
    endtask

    task automatic check_idle_after(input string tag);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: got busy %b done %b wr_en %b expected 0 0 0",
                     tag, busy, done, wr_en);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (mem_addr !== 4'd0 || op_a !== 16'd0 || op_b !== 16'd0 || wr_en !== 1'b0 ||
                wr_addr !== 3'd0 || wr_data !== 32'd0 || mul_start !== 1'b0 ||
                busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got addr %0d a %0d b %0d wr %b/%0d/%0d ms %b busy %b done %b err %b expected all 0",
                         k, mem_addr, op_a, op_b, wr_en, wr_addr, wr_data, mul_start, busy, done, error);
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wq_addr.size() !== 0) begin
            errors++;
            $display("FAIL reset_release: got busy %b writes %0d expected 0 0", busy, wq_addr.size());
        end
    endtask

    task automatic test_full_run();
        int cyc;
        for (int k = 0; k < 16; k++) mem[k] = 16'(k + 1);
        mode = 0;
        clear_log();
        run_once(100, 1'b0, cyc);
        checks++;
        if (cyc !== 41) begin
            errors++;
            $display("FAIL full_run done_cycle: got %0d expected 41", cyc);
        end
        checks++;
        if (exp_prod(7) !== 32'd240 || exp_prod(0) !== 32'd2) begin
            errors++;
            $display("FAIL full_run memory_image: got %0d/%0d expected 2/240", exp_prod(0), exp_prod(7));
        end
        check_products("full_run");
        check_idle_after("full_run");
    endtask

    task automatic test_variable_latency();
        int cyc;
        int exp_cyc;
        mode = 1;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 16; k++) mem[k] = 16'($urandom);
            clear_log();
            run_once(300, 1'b0, cyc);
            exp_cyc = 41;
            foreach (delays[j]) exp_cyc += delays[j];
            checks++;
            if (cyc !== exp_cyc) begin
                errors++;
                $display("FAIL var_latency[%0d] done_cycle: got %0d expected %0d", r, cyc, exp_cyc);
            end
            check_products("var_latency");
            checks++;
            if (stab_viol !== 0) begin
                errors++;
                $display("FAIL var_latency[%0d] operand_stability: got %0d changes expected 0", r, stab_viol);
            end
            check_idle_after("var_latency");
        end
        mode = 0;
    endtask

    task automatic test_timeout();
        int cyc;
        for (int k = 0; k < 16; k++) mem[k] = 16'($urandom);
        mode = 2;
        clear_log();
        run_once(400, 1'b0, cyc);
        checks++;
        if (cyc !== 259 || error !== 1'b1) begin
            errors++;
            $display("FAIL timeout done: got cycle %0d error %b expected 259 1", cyc, error);
        end
        checks++;
        if (wq_addr.size() !== 0 || n_start !== 1) begin
            errors++;
            $display("FAIL timeout activity: got writes %0d mul_starts %0d expected 0 1",
                     wq_addr.size(), n_start);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout sticky: got error %b busy %b expected 1 0", error, busy);
        end
        mode = 0;
        clear_log();
        run_once(100, 1'b0, cyc);
        checks++;
        if (first_err !== 1'b0 || cyc !== 41 || error !== 1'b0) begin
            errors++;
            $display("FAIL timeout recovery: got first_err %b cycle %0d error %b expected 0 41 0",
                     first_err, cyc, error);
        end
        check_products("timeout_recovery");
    endtask

    task automatic test_midrun_reset();
        int cyc;
        for (int k = 0; k < 16; k++) mem[k] = 16'($urandom);
        mode = 0;
        clear_log();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);  // cycle 19: WAIT_MUL of pair 3
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || mul_start !== 1'b0 || done !== 1'b0 || mem_addr !== 4'd0) begin
            errors++;
            $display("FAIL midrun_reset state: got busy %b wr_en %b ms %b done %b addr %0d expected 0 0 0 0 0",
                     busy, wr_en, mul_start, done, mem_addr);
        end
        rst = 1'b0;
        checks++;
        if (wq_addr.size() !== 3) begin
            errors++;
            $display("FAIL midrun_reset writes: got %0d expected 3", wq_addr.size());
        end
        @(negedge clk);
        clear_log();
        run_once(100, 1'b0, cyc);
        checks++;
        if (first_addr !== 4'd0 || cyc !== 41) begin
            errors++;
            $display("FAIL midrun_reset restart: got addr %0d cycle %0d expected 0 41", first_addr, cyc);
        end
        check_products("midrun_restart");
    endtask

    task automatic test_spurious();
        int cyc;
        for (int k = 0; k < 16; k++) mem[k] = 16'(k + 1);
        mode = 0;
        clear_log();
        run_once(100, 1'b1, cyc);
        checks++;
        if (cyc !== 41) begin
            errors++;
            $display("FAIL spurious done_cycle: got %0d expected 41", cyc);
        end
        check_products("spurious");
        check_idle_after("spurious");
        repeat (3) @(negedge clk);
        checks++;
        if (wq_addr.size() !== 8 || busy !== 1'b0) begin
            errors++;
            $display("FAIL spurious extra_run: got writes %0d busy %b expected 8 0", wq_addr.size(), busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int guard;
        for (int k = 0; k < 16; k++) mem[k] = 16'($urandom);
        mode = 0;
        clear_log();
        run_once(100, 1'b0, cyc);
        start = 1'b1;           // held high through DONE: second run launches from IDLE
        @(negedge clk);
        guard = 0;
        while (busy !== 1'b1 && guard < 5) begin
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        guard = 0;
        while (done !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (cyc !== 41 || done !== 1'b1 || wq_addr.size() !== 16) begin
            errors++;
            $display("FAIL back_to_back: got first_cycle %0d done %b writes %0d expected 41 1 16",
                     cyc, done, wq_addr.size());
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mem[k] = '0;
        test_reset();
        test_full_run();
        test_variable_latency();
        test_timeout();
        test_midrun_reset();
        test_spurious();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
